sr_cmd_debouncer: RTL
=====================

# sr_cmd_debouncer

Upstream command stage for the SR flip-flop. It takes two raw, possibly bouncing, asynchronous set/reset request lines, synchronises and debounces them, and arbitrates between them. It emits clean, mutually exclusive, single-cycle `S`/`R` pulses that drive the flip-flop's `S` and `R` inputs directly on the same clock.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a level change. Legal range is 2..65535.
- `HOLDOFF_CYCLES`, default 4: idle cycles enforced after every emitted pulse. Legal range is 1..255.

Ports:
- `clk`  input  1  Single clock. All logic is rising-edge.
- `rst`  input  1  Asynchronous, active-high reset.
- `set_in`  input  1  Raw set request. Asynchronous and may bounce.
- `reset_in`  input  1  Raw reset request. Asynchronous and may bounce.
- `S`  output  1  One-cycle set pulse to the flip-flop.
- `R`  output  1  One-cycle reset pulse to the flip-flop.
- `busy`  output  1  High while a pulse or holdoff is in progress.
- `conflict`  output  1  One-cycle flag: set and reset requests were accepted on the same cycle.

## Operation

- **Reset values:** all outputs are 0 and the FSM is in IDLE.
  - Synchroniser flops, debounced levels, counters and pending bits are all cleared.
- **Synchroniser:** each input passes through a 2-flop synchroniser.
- **Debounce, per channel:**
  - The counter increments while the synchronised sample differs from the debounced level.
  - The counter clears to 0 whenever the sample equals the debounced level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - Counter width is clog2(`DEBOUNCE_CYCLES`+1). The counter saturates and never wraps.
- **Request:** a 0→1 transition of a debounced level raises a one-cycle request for that channel. A 1→0 transition produces nothing.
- **FSM states:** IDLE, PULSE_S, PULSE_R, HOLDOFF.
  - IDLE: with a reset request or pending-R, go to PULSE_R. Otherwise, with a set request or pending-S, go to PULSE_S. Otherwise stay.
  - PULSE_S: `S`=1 for exactly this cycle, then go to HOLDOFF.
  - PULSE_R: `R`=1 for exactly this cycle, then go to HOLDOFF.
  - HOLDOFF: a counter runs for `HOLDOFF_CYCLES` cycles, then the FSM returns to IDLE.
  - `busy` is high in PULSE_S, PULSE_R and HOLDOFF.
- **Priority:** reset wins over set.
  - If both requests arrive in the same cycle in IDLE, go to PULSE_R and pulse `conflict` on that cycle.
  - The losing set request is discarded.
- **Invariant:** `S` and `R` are never high in the same cycle.
- **Requests while busy:** handling is governed by the Configuration section.
- **Reset mid-operation:** asserting `rst` aborts any pulse immediately (asynchronously).
  - After release, an input already high is treated as a new edge once it has been debounced, so it produces a pulse.

## Timing

- **Latency:** a clean input rising edge first sampled at clock edge t produces `S`/`R` high during the cycle after edge t+2+`DEBOUNCE_CYCLES`, with the FSM in IDLE. This is a fixed latency of `DEBOUNCE_CYCLES`+3 cycles.
- **Pulse spacing:** consecutive pulses are at least `HOLDOFF_CYCLES`+1 cycles apart.
- **Bounce rejection:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no pulse and leaves the debounced level unchanged.
- **Output registers:** `S`, `R`, `busy` and `conflict` are registered outputs with no combinational path from the inputs.

## Configuration

- `SR_CMD_PENDING_EN` defined:
  - A request arriving while `busy` sets a one-deep pending bit for its channel.
  - A second request on the same channel while its bit is already set is merged into it.
  - Pending bits are served in IDLE, with pending-R before pending-S.
  - If both pending bits are set when IDLE is reached, `conflict` pulses and pending-S is dropped.
- `SR_CMD_PENDING_EN` undefined:
  - Pending logic is absent and requests arriving while `busy` are dropped silently.

## Test plan

- **Reset:** hold `rst`=1 mid-HOLDOFF, then release. All outputs are 0 and the FSM is in IDLE. With `set_in` held high, `S` pulses once after 19 cycles (defaults).
- **Clean set:** with defaults, raise `set_in` and hold it. `S`=1 for exactly one cycle, 19 cycles after the first sampling edge. `R` stays 0 and `busy` is high for 5 cycles.
- **Bounce:** toggle `set_in` every 5 cycles for 60 cycles, then return it to 0. There is no `S` pulse and no `busy`.
- **Simultaneous:** raise `set_in` and `reset_in` on the same edge. `R` pulses once, `conflict` pulses in that same cycle, and no `S` follows.
- **Busy request:** raise `reset_in`, then raise `set_in` so that it is accepted 2 cycles into HOLDOFF.
  - With `SR_CMD_PENDING_EN`: `S` pulses in the cycle after HOLDOFF ends.
  - Without it: no `S` pulse.
- **Release edge:** drop `set_in` after an accepted set. No pulse is produced on the falling edge.

Source files
------------

// File: rtl/sr_cmd_debouncer.sv
// Synchronises, debounces and arbitrates raw set/reset requests into clean,
// mutually exclusive one-cycle S/R pulses. Define SR_CMD_PENDING_EN to queue requests seen while busy.
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic reset_in,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, HOLDOFF} state_e;

  // Channel 0 = set, channel 1 = reset.
  logic [1:0]         raw, sync1_q, sync2_q, lvl_q, lvl_d, req_q, req_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic               want_s, want_r;
  logic               s_d, r_d, busy_d, conflict_d;

  assign raw = {reset_in, set_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  // Toggle on the DEBOUNCE_CYCLES-th consecutive differing sample; only rising toggles request.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    req_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        lvl_d[i] = ~lvl_q[i];
        req_d[i] = ~lvl_q[i];
      end else if (cnt_q[i] != CNT_SAT) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

`ifdef SR_CMD_PENDING_EN
  logic pend_s_q, pend_r_q, pend_s_d, pend_r_d;

  assign want_s = req_q[0] | pend_s_q;
  assign want_r = req_q[1] | pend_r_q;

  // Reset service also discards any set competing in the same IDLE cycle.
  always_comb begin
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    if (state_q == IDLE) begin
      if (want_r) begin
        pend_r_d = 1'b0;
        pend_s_d = 1'b0;
      end else if (want_s) begin
        pend_s_d = 1'b0;
      end
    end else begin
      if (req_q[0]) pend_s_d = 1'b1;
      if (req_q[1]) pend_r_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
    end else begin
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
    end
  end
`else
  assign want_s = req_q[0];
  assign want_r = req_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (want_r)      state_d = PULSE_R;
        else if (want_s) state_d = PULSE_S;
      end
      PULSE_S, PULSE_R: begin
        state_d = HOLDOFF;
        hcnt_d  = '0;
      end
      HOLDOFF: begin
        if (hcnt_q == HLD_LAST) state_d = IDLE;
        else                    hcnt_d  = hcnt_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    s_d        = (state_d == PULSE_S);
    r_d        = (state_d == PULSE_R);
    busy_d     = (state_d != IDLE);
    conflict_d = (state_q == IDLE) && want_r && want_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= s_d;
      R        <= r_d;
      busy     <= busy_d;
      conflict <= conflict_d;
    end
  end
endmodule
